m_lcd_rect_sched: RTL and testbench
===================================

M_LCD_RECT_SCHED -- requirements
Module: m_lcd_rect_sched

Interface
REQ-001 Parameter LCD_W, default 240, meaning panel width in pixels.
REQ-002 Parameter LCD_H, default 240, meaning panel height in pixels.
REQ-003 w_clk  input  1  system clock (100 MHz).
REQ-004 w_rst_n  input  1  reset; one clock, synchronous, active-low.
REQ-005 w_req_valid  input  1  rectangle update request.
REQ-006 w_req_ready  output  1  scheduler can accept a request.
REQ-007 w_req_x0, w_req_y0, w_req_x1, w_req_y1  input  8 each  inclusive rectangle corners.
REQ-008 w_raddr  output  `VMEM_ADDRW  VRAM read address, {y, x}.
REQ-009 w_rdata  input  16  RGB565 pixel, valid one cycle after w_raddr.
REQ-010 w_spi_en  output  1  one-cycle byte-send strobe to the SPI byte engine.
REQ-011 w_spi_data  output  9  {DC, byte}; DC=0 command, DC=1 data.
REQ-012 w_spi_busy  input  1  SPI engine busy; the engine's busy includes its own en input.
REQ-013 w_idle  output  1  no rectangle in progress.
REQ-014 w_err  output  1  one-cycle pulse on a rejected request.

Function
REQ-015 States: IDLE, CMD, FETCH, PIX_HI, PIX_LO; the scheduler SHALL leave IDLE only on an accepted valid request.
REQ-016 w_req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle with w_req_valid && w_req_ready, and the corners are latched that cycle.
REQ-017 A request with x0>x1, y0>y1, x1>=LCD_W or y1>=LCD_H SHALL be accepted, pulse w_err for exactly one cycle the next cycle, and remain in IDLE.
REQ-018 CMD SHALL send 11 bytes in order: 0x2A(DC0), 0x00, x0, 0x00, x1, 0x2B(DC0), 0x00, y0, 0x00, y1 (all DC1), then 0x2C(DC0).
REQ-019 The pixel phase SHALL send (x1-x0+1)*(y1-y0+1) pixels in row-major order, x0..x1 within each row and rows y0..y1, each as the high byte and then the low byte, both DC1.
REQ-020 FETCH SHALL drive w_raddr={y,x} and hold the captured w_rdata in a register before the high byte is issued; w_raddr SHALL remain stable while that pixel is sent.
REQ-021 Strobe rule: w_spi_en SHALL be asserted for one cycle only when w_spi_busy=0 and w_spi_en was 0 in the previous cycle.
REQ-022 w_spi_data SHALL be stable in the cycle w_spi_en=1.
REQ-023 Exactly one byte SHALL be issued per strobe, and no byte SHALL be skipped or duplicated.
REQ-024 After the low byte of pixel (x1,y1) is strobed, the state SHALL return to IDLE, and w_idle and w_req_ready SHALL rise the next cycle.
REQ-025 A rectangle with x0=x1 and y0=y1 SHALL send 11 command bytes plus 2 pixel bytes.
REQ-026 A full-panel rectangle (0,0,239,239) SHALL send 11+115200 bytes.
REQ-027 x and y counters SHALL be 8 bits and SHALL never wrap, because the corners are bounded by LCD_W-1 and LCD_H-1.
REQ-028 w_req_valid during a transfer SHALL be ignored; the requester holds it until w_req_ready=1.

Reset
REQ-029 While w_rst_n=0 at a clock edge: state=IDLE, w_spi_en=0, w_spi_data=0, w_raddr=0, w_err=0, w_idle=1, w_req_ready=1, and the latched corners and counters are 0.
REQ-030 A reset mid-transfer SHALL abandon the rectangle with no further strobes.
REQ-031 Any byte already in the SPI engine SHALL finish unaffected.
REQ-032 The first strobe after reset SHALL obey REQ-021.

Structure
REQ-033 A shared package SHALL hold the state enum, the command codes 0x2A/0x2B/0x2C, and the LCD_W/LCD_H defaults.
REQ-034 One sub-module, m_spi_issue, SHALL implement the en/busy strobe rule of REQ-021 and the data hold of REQ-022.
REQ-035 The sequencing and counters SHALL reside in m_lcd_rect_sched.

Verification
REQ-036 Request (10,20,10,20) with VRAM[{20,10}]=0xF800 -> byte stream 2A,00,0A,00,0A,2B,00,14,00,14,2C,F8,00 with the correct DC per byte, then w_idle=1.
REQ-037 Request (0,0,239,239) with VRAM = address pattern -> 115211 bytes, and the pixel order matches row-major {y,x}.
REQ-038 Request (5,0,4,0) -> w_err pulses once, no w_spi_en, w_req_ready stays 1.
REQ-039 Random busy stretching of 0-50 cycles on the SPI engine model -> no strobe while busy, no back-to-back strobes, identical byte stream.
REQ-040 w_rst_n low for 1 cycle after byte 500 of a 2x300-byte rectangle -> strobes stop, IDLE, w_req_ready=1; a new request (0,0,0,0) then completes correctly.
REQ-041 w_req_valid asserted with new corners mid-transfer -> ignored until IDLE, then accepted with the held corners.

Source files
------------

// File: rtl/m_lcd_rect_sched_pkg.sv
// Shared definitions for the LCD rectangle scheduler: FSM states, panel
// command codes, default panel geometry and the command-byte sequencer.
package m_lcd_rect_sched_pkg;

  localparam int LCD_W_DEF  = 240;
  localparam int LCD_H_DEF  = 240;
  localparam int VMEM_ADDRW = 16;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  // Index of the final command byte (RAMWR) in the 11-byte preamble.
  localparam logic [3:0] CMD_LAST_IDX = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_FETCH  = 3'd2,
    ST_PIX_HI = 3'd3,
    ST_PIX_LO = 3'd4
  } state_t;

  // {DC, byte} for position idx of the window-setup preamble.
  function automatic logic [8:0] f_cmd_byte(input logic [3:0] idx,
                                            input logic [7:0] x0,
                                            input logic [7:0] x1,
                                            input logic [7:0] y0,
                                            input logic [7:0] y1);
    logic [8:0] b;
    case (idx)
      4'd0:    b = {1'b0, CMD_CASET};
      4'd1:    b = {1'b1, 8'h00};
      4'd2:    b = {1'b1, x0};
      4'd3:    b = {1'b1, 8'h00};
      4'd4:    b = {1'b1, x1};
      4'd5:    b = {1'b0, CMD_RASET};
      4'd6:    b = {1'b1, 8'h00};
      4'd7:    b = {1'b1, y0};
      4'd8:    b = {1'b1, 8'h00};
      4'd9:    b = {1'b1, y1};
      4'd10:   b = {1'b0, CMD_RAMWR};
      default: b = 9'd0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/m_lcd_rect_sched_if.sv
// Request, VRAM and SPI-engine signals of the rectangle scheduler.
// slave = scheduler side, master = environment side.
interface m_lcd_rect_sched_if;
  import m_lcd_rect_sched_pkg::*;

  logic                  w_req_valid;
  logic                  w_req_ready;
  logic [7:0]            w_req_x0;
  logic [7:0]            w_req_y0;
  logic [7:0]            w_req_x1;
  logic [7:0]            w_req_y1;
  logic [VMEM_ADDRW-1:0] w_raddr;
  logic [15:0]           w_rdata;
  logic                  w_spi_en;
  logic [8:0]            w_spi_data;
  logic                  w_spi_busy;
  logic                  w_idle;
  logic                  w_err;

  modport slave (
    input  w_req_valid, w_req_x0, w_req_y0, w_req_x1, w_req_y1,
    input  w_rdata, w_spi_busy,
    output w_req_ready, w_raddr, w_spi_en, w_spi_data, w_idle, w_err
  );

  modport master (
    output w_req_valid, w_req_x0, w_req_y0, w_req_x1, w_req_y1,
    output w_rdata, w_spi_busy,
    input  w_req_ready, w_raddr, w_spi_en, w_spi_data, w_idle, w_err
  );

endinterface

// File: rtl/m_spi_issue.sv
// Byte strobe generator toward the SPI byte engine. A pending byte is
// strobed only when the engine is not busy and no strobe was issued in
// the previous cycle; the data register holds the byte for the strobe.
module m_spi_issue (
  input  logic       w_clk,
  input  logic       w_rst_n,
  input  logic       w_byte_valid,
  input  logic [8:0] w_byte,
  input  logic       w_spi_busy,
  output logic       w_spi_en,
  output logic [8:0] w_spi_data
);

  logic       en_r;
  logic [8:0] data_r;
  logic       fire_s;

  assign fire_s = w_byte_valid && !w_spi_busy && !en_r;

  // Register the strobe and latch its byte on the deciding edge.
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      en_r   <= 1'b0;
      data_r <= 9'd0;
    end else begin
      en_r <= fire_s;
      if (fire_s) begin
        data_r <= w_byte;
      end else begin
        data_r <= data_r;
      end
    end
  end

  assign w_spi_en   = en_r;
  assign w_spi_data = data_r;

endmodule

// File: rtl/m_lcd_rect_sched.sv
// LCD rectangle scheduler: accepts a window, sends the CASET/RASET/RAMWR
// preamble, then streams the window's VRAM pixels row-major as RGB565
// high/low byte pairs. One byte is outstanding at a time; the sequencer
// advances only when the issue stage actually strobes the byte.
module m_lcd_rect_sched
  import m_lcd_rect_sched_pkg::*;
#(
  parameter int LCD_W = LCD_W_DEF,
  parameter int LCD_H = LCD_H_DEF
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  m_lcd_rect_sched_if.slave bus
);

  localparam logic [8:0] LCD_W9 = 9'(LCD_W);
  localparam logic [8:0] LCD_H9 = 9'(LCD_H);

  state_t                state_r;
  state_t                state_nx_s;
  logic [7:0]            x0_r, y0_r, x1_r, y1_r;
  logic [7:0]            x_r, y_r;
  logic [3:0]            cmd_idx_r;
  logic                  fetch_ph_r;
  logic [15:0]           pix_r;
  logic [VMEM_ADDRW-1:0] raddr_r;
  logic                  err_r, ready_r, idle_r;

  logic                  accept_s, bad_s, strobed_s, last_pix_s;
  logic                  byte_valid_s;
  logic [8:0]            byte_s;
  logic                  spi_en_s;
  logic [8:0]            spi_data_s;

  assign accept_s   = bus.w_req_valid && ready_r;
  assign bad_s      = (bus.w_req_x0 > bus.w_req_x1) ||
                      (bus.w_req_y0 > bus.w_req_y1) ||
                      ({1'b0, bus.w_req_x1} >= LCD_W9) ||
                      ({1'b0, bus.w_req_y1} >= LCD_H9);
  assign strobed_s  = spi_en_s;
  assign last_pix_s = (x_r == x1_r) && (y_r == y1_r);

  // State register.
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state: each byte-sending state waits for its own strobe.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && !bad_s) state_nx_s = ST_CMD;
        else                    state_nx_s = ST_IDLE;
      end
      ST_CMD: begin
        if (strobed_s && (cmd_idx_r == CMD_LAST_IDX)) state_nx_s = ST_FETCH;
        else                                          state_nx_s = ST_CMD;
      end
      ST_FETCH: begin
        if (fetch_ph_r) state_nx_s = ST_PIX_HI;
        else            state_nx_s = ST_FETCH;
      end
      ST_PIX_HI: begin
        if (strobed_s) state_nx_s = ST_PIX_LO;
        else           state_nx_s = ST_PIX_HI;
      end
      ST_PIX_LO: begin
        if (strobed_s) begin
          if (last_pix_s) state_nx_s = ST_IDLE;
          else            state_nx_s = ST_FETCH;
        end else begin
          state_nx_s = ST_PIX_LO;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Byte presented to the issue stage for the current state.
  always_comb begin
    byte_valid_s = 1'b0;
    byte_s       = 9'd0;
    case (state_r)
      ST_CMD: begin
        byte_valid_s = 1'b1;
        byte_s       = f_cmd_byte(cmd_idx_r, x0_r, x1_r, y0_r, y1_r);
      end
      ST_PIX_HI: begin
        byte_valid_s = 1'b1;
        byte_s       = {1'b1, pix_r[15:8]};
      end
      ST_PIX_LO: begin
        byte_valid_s = 1'b1;
        byte_s       = {1'b1, pix_r[7:0]};
      end
      default: begin
        byte_valid_s = 1'b0;
        byte_s       = 9'd0;
      end
    endcase
  end

  // Corner latch, command index, pixel walk, VRAM capture and status flags.
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      x0_r       <= 8'd0;
      y0_r       <= 8'd0;
      x1_r       <= 8'd0;
      y1_r       <= 8'd0;
      x_r        <= 8'd0;
      y_r        <= 8'd0;
      cmd_idx_r  <= 4'd0;
      fetch_ph_r <= 1'b0;
      pix_r      <= 16'd0;
      raddr_r    <= '0;
      err_r      <= 1'b0;
      ready_r    <= 1'b1;
      idle_r     <= 1'b1;
    end else begin
      ready_r <= (state_nx_s == ST_IDLE);
      idle_r  <= (state_nx_s == ST_IDLE);
      err_r   <= accept_s && bad_s;

      if (accept_s) begin
        x0_r <= bus.w_req_x0;
        y0_r <= bus.w_req_y0;
        x1_r <= bus.w_req_x1;
        y1_r <= bus.w_req_y1;
      end

      if (state_r == ST_IDLE) begin
        cmd_idx_r <= 4'd0;
      end else if ((state_r == ST_CMD) && strobed_s) begin
        cmd_idx_r <= cmd_idx_r + 4'd1;
      end

      // VRAM data lands one cycle after the address: two-cycle FETCH.
      fetch_ph_r <= (state_r == ST_FETCH) && !fetch_ph_r;
      if ((state_r == ST_FETCH) && fetch_ph_r) begin
        pix_r <= bus.w_rdata;
      end

      // Address stays put while its pixel's two bytes are sent.
      if ((state_r == ST_CMD) && strobed_s && (cmd_idx_r == CMD_LAST_IDX)) begin
        x_r     <= x0_r;
        y_r     <= y0_r;
        raddr_r <= {y0_r, x0_r};
      end else if ((state_r == ST_PIX_LO) && strobed_s && !last_pix_s) begin
        if (x_r == x1_r) begin
          x_r     <= x0_r;
          y_r     <= y_r + 8'd1;
          raddr_r <= {y_r + 8'd1, x0_r};
        end else begin
          x_r     <= x_r + 8'd1;
          raddr_r <= {y_r, x_r + 8'd1};
        end
      end
    end
  end

  m_spi_issue u_issue (
    .w_clk        (w_clk),
    .w_rst_n      (w_rst_n),
    .w_byte_valid (byte_valid_s),
    .w_byte       (byte_s),
    .w_spi_busy   (bus.w_spi_busy),
    .w_spi_en     (spi_en_s),
    .w_spi_data   (spi_data_s)
  );

  assign bus.w_spi_en    = spi_en_s;
  assign bus.w_spi_data  = spi_data_s;
  assign bus.w_raddr     = raddr_r;
  assign bus.w_req_ready = ready_r;
  assign bus.w_idle      = idle_r;
  assign bus.w_err       = err_r;

endmodule

// File: tb/tb_m_lcd_rect_sched.sv
// Directed bench for m_lcd_rect_sched with a VRAM model and an SPI byte
// engine model whose busy time is stretched randomly.
module tb_m_lcd_rect_sched;

  logic w_clk = 1'b0;
  logic w_rst_n;

  m_lcd_rect_sched_if bus();

  m_lcd_rect_sched #(.LCD_W(240), .LCD_H(240)) dut (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .bus     (bus)
  );

  always #5 w_clk = ~w_clk;

  logic [15:0] vram [0:65535];
  logic [15:0] rdata_r;
  int          busy_cnt    = 0;
  int          max_stretch = 0;
  logic        prev_busy   = 1'b0;
  int          viol_cnt    = 0;
  int          en_cnt      = 0;
  int          err_cnt     = 0;
  int          cyc         = 0;
  int          last_en_cyc = 0;
  logic [8:0]  got_q [$];
  logic [8:0]  exp_q [$];
  int          n_vec = 0;
  int          n_bad = 0;

  assign bus.w_spi_busy = bus.w_spi_en || (busy_cnt != 0);
  assign bus.w_rdata    = rdata_r;

  // VRAM: synchronous read, data valid the cycle after the address.
  always @(posedge w_clk) rdata_r <= vram[bus.w_raddr];

  // SPI engine model and strobe-rule monitor (engine ignores DUT reset).
  always @(posedge w_clk) begin
    cyc       <= cyc + 1;
    prev_busy <= bus.w_spi_busy;
    if (bus.w_spi_en) begin
      got_q.push_back(bus.w_spi_data);
      en_cnt      <= en_cnt + 1;
      last_en_cyc <= cyc;
      busy_cnt    <= int'($urandom_range(max_stretch, 0));
      if (prev_busy) viol_cnt <= viol_cnt + 1;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (bus.w_err) err_cnt <= err_cnt + 1;
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_cmd(input logic [7:0] x0, input logic [7:0] y0,
                          input logic [7:0] x1, input logic [7:0] y1);
    exp_q.push_back(9'h02A); exp_q.push_back(9'h100); exp_q.push_back({1'b1, x0});
    exp_q.push_back(9'h100); exp_q.push_back({1'b1, x1});
    exp_q.push_back(9'h02B); exp_q.push_back(9'h100); exp_q.push_back({1'b1, y0});
    exp_q.push_back(9'h100); exp_q.push_back({1'b1, y1});
    exp_q.push_back(9'h02C);
  endtask

  task automatic push_pix(input logic [7:0] x0, input logic [7:0] y0,
                          input logic [7:0] x1, input logic [7:0] y1);
    logic [15:0] p;
    for (int y = int'(y0); y <= int'(y1); y++) begin
      for (int x = int'(x0); x <= int'(x1); x++) begin
        p = vram[{8'(y), 8'(x)}];
        exp_q.push_back({1'b1, p[15:8]});
        exp_q.push_back({1'b1, p[7:0]});
      end
    end
  endtask

  task automatic send_req(input logic [7:0] x0, input logic [7:0] y0,
                          input logic [7:0] x1, input logic [7:0] y1, input string tag);
    bit done = 1'b0;
    @(negedge w_clk);
    bus.w_req_valid = 1'b1;
    bus.w_req_x0 = x0; bus.w_req_y0 = y0; bus.w_req_x1 = x1; bus.w_req_y1 = y1;
    for (int i = 0; i < 20000 && !done; i++) begin
      if (bus.w_req_ready) begin
        @(posedge w_clk);
        done = 1'b1;
      end else begin
        @(negedge w_clk);
      end
    end
    if (!done) chk_val({tag, " accept timeout"}, 32'd0, 32'd1);
    @(negedge w_clk);
    bus.w_req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    bit done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge w_clk);
      if (bus.w_idle) done = 1'b1;
    end
    if (!done) chk_val({tag, " idle timeout"}, 32'd0, 32'd1);
  endtask

  task automatic compare_stream(input string tag);
    chk_val({tag, " byte count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk_val($sformatf("%s byte %0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      if (got_q[i] !== exp_q[i]) break;
    end
    chk_val({tag, " strobe rule"}, viol_cnt, 0);
    got_q.delete();
    exp_q.delete();
  endtask

  logic [8:0] t1_exp [13] = '{9'h02A, 9'h100, 9'h10A, 9'h100, 9'h10A, 9'h02B, 9'h100,
                              9'h114, 9'h100, 9'h114, 9'h02C, 9'h1F8, 9'h100};
  logic [7:0] rej_tab [4][4] = '{'{8'd5, 8'd0, 8'd4,   8'd0},
                                 '{8'd0, 8'd0, 8'd240, 8'd0},
                                 '{8'd0, 8'd0, 8'd0,   8'd240},
                                 '{8'd0, 8'd5, 8'd0,   8'd4}};

  initial begin
    int base_en;
    int base_err;
    int rise_cyc;
    bit hit;
    bus.w_req_valid = 1'b0;
    bus.w_req_x0 = 8'd0; bus.w_req_y0 = 8'd0; bus.w_req_x1 = 8'd0; bus.w_req_y1 = 8'd0;
    for (int a = 0; a < 65536; a++) vram[a] = 16'(a);
    vram[16'h140A] = 16'hF800;

    // Reset state
    w_rst_n = 1'b0;
    repeat (3) @(negedge w_clk);
    chk_val("rst ready", 32'(bus.w_req_ready), 32'd1);
    chk_val("rst idle",  32'(bus.w_idle),      32'd1);
    chk_val("rst en",    32'(bus.w_spi_en),    32'd0);
    chk_val("rst data",  32'(bus.w_spi_data),  32'd0);
    chk_val("rst raddr", 32'(bus.w_raddr),     32'd0);
    chk_val("rst err",   32'(bus.w_err),       32'd0);
    w_rst_n = 1'b1;

    // Single pixel, hand-computed stream, idle timing
    max_stretch = 3;
    send_req(8'd10, 8'd20, 8'd10, 8'd20, "t1");
    wait_idle(2000, "t1");
    rise_cyc = cyc;
    chk_val("t1 idle rise cycle", rise_cyc, last_en_cyc + 1);
    chk_val("t1 ready", 32'(bus.w_req_ready), 32'd1);
    foreach (t1_exp[i]) exp_q.push_back(t1_exp[i]);
    compare_stream("t1");

    // Rejected requests
    for (int r = 0; r < 4; r++) begin
      base_en  = en_cnt;
      base_err = err_cnt;
      @(negedge w_clk);
      bus.w_req_valid = 1'b1;
      bus.w_req_x0 = rej_tab[r][0]; bus.w_req_y0 = rej_tab[r][1];
      bus.w_req_x1 = rej_tab[r][2]; bus.w_req_y1 = rej_tab[r][3];
      @(negedge w_clk);
      bus.w_req_valid = 1'b0;
      chk_val($sformatf("rej%0d err pulse", r), 32'(bus.w_err), 32'd1);
      @(negedge w_clk);
      chk_val($sformatf("rej%0d err drop", r), 32'(bus.w_err), 32'd0);
      chk_val($sformatf("rej%0d ready", r), 32'(bus.w_req_ready), 32'd1);
      repeat (8) @(negedge w_clk);
      chk_val($sformatf("rej%0d strobes", r), en_cnt - base_en, 0);
      chk_val($sformatf("rej%0d err count", r), err_cnt - base_err, 1);
      chk_val($sformatf("rej%0d idle", r), 32'(bus.w_idle), 32'd1);
    end

    // Same window under heavy and no busy stretching
    for (int s = 0; s < 2; s++) begin
      max_stretch = (s == 0) ? 50 : 0;
      send_req(8'd3, 8'd4, 8'd5, 8'd5, "stretch");
      wait_idle(5000, "stretch");
      push_cmd(8'd3, 8'd4, 8'd5, 8'd5);
      push_pix(8'd3, 8'd4, 8'd5, 8'd5);
      compare_stream($sformatf("stretch%0d", s));
    end

    // Panel-edge window: full width, last rows, address-pattern pixels
    max_stretch = 0;
    send_req(8'd0, 8'd236, 8'd239, 8'd239, "edge");
    wait_idle(30000, "edge");
    push_cmd(8'd0, 8'd236, 8'd239, 8'd239);
    push_pix(8'd0, 8'd236, 8'd239, 8'd239);
    compare_stream("edge");

    // Reset after byte 500 of a 611-byte transfer, then a 1x1 window
    max_stretch = 1;
    base_en = en_cnt;
    send_req(8'd0, 8'd0, 8'd149, 8'd1, "mid");
    hit = 1'b0;
    for (int i = 0; i < 5000 && !hit; i++) begin
      if (en_cnt - base_en >= 500) hit = 1'b1;
      else @(negedge w_clk);
    end
    if (!hit) chk_val("mid reach 500", 32'd0, 32'd1);
    w_rst_n = 1'b0;
    @(negedge w_clk);
    w_rst_n = 1'b1;
    repeat (60) @(negedge w_clk);
    chk_val("mid strobes after reset", en_cnt - base_en, 500);
    chk_val("mid ready", 32'(bus.w_req_ready), 32'd1);
    chk_val("mid idle", 32'(bus.w_idle), 32'd1);
    push_cmd(8'd0, 8'd0, 8'd149, 8'd1);
    push_pix(8'd0, 8'd0, 8'd149, 8'd1);
    while (exp_q.size() > 500) void'(exp_q.pop_back());
    compare_stream("mid");
    send_req(8'd0, 8'd0, 8'd0, 8'd0, "post");
    wait_idle(2000, "post");
    push_cmd(8'd0, 8'd0, 8'd0, 8'd0);
    push_pix(8'd0, 8'd0, 8'd0, 8'd0);
    compare_stream("post");

    // New request held during a transfer is taken only once idle
    max_stretch = 2;
    send_req(8'd1, 8'd1, 8'd2, 8'd1, "holdA");
    send_req(8'd7, 8'd8, 8'd7, 8'd8, "holdB");
    wait_idle(2000, "holdB");
    push_cmd(8'd1, 8'd1, 8'd2, 8'd1);
    push_pix(8'd1, 8'd1, 8'd2, 8'd1);
    push_cmd(8'd7, 8'd8, 8'd7, 8'd8);
    push_pix(8'd7, 8'd8, 8'd7, 8'd8);
    compare_stream("hold");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
